// File: rtl/riscv_boot_pkg.sv
// riscv_boot_pkg: shared state, error codes and defaults for the boot image loader
package riscv_boot_pkg;
    localparam int IMEM_DEPTH_DEF = 128;
    localparam int TIMEOUT_DEF = 1000000;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, WRITE, CHECK, DONE, ERROR} loader_state_t;
    typedef logic [1:0] boot_err_t;
    localparam boot_err_t ERR_NONE = 2'b00;
    localparam boot_err_t ERR_CSUM = 2'b01;
    localparam boot_err_t ERR_OVF = 2'b10;
    localparam boot_err_t ERR_TMO = 2'b11;
    function automatic logic in_frame(input loader_state_t s);
        return s inside {CNT_LO, CNT_HI, DATA, WRITE, CHECK};
    endfunction
endpackage

// File: rtl/boot_timeout_cnt.sv
// boot_timeout_cnt: counts idle cycles and flags the cycle that would reach the limit
module boot_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt;
    assign expired = enable && cnt == W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed, checksummed boot image and writes it into instruction memory
module imem_loader
    import riscv_boot_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int ADDR_W = $clog2(IMEM_DEPTH),
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              boot_skip,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   words_loaded
);
    loader_state_t state, next;
    boot_err_t err_n;
    logic acc, start, expired, last, tmo_en;
    logic [7:0] cnt_lo, csum;
    logic [15:0] count, cnt16;
    logic [1:0] bidx;
    logic [23:0] buf_q;

    assign cnt16 = {in_data, cnt_lo};
    assign last = 16'(words_loaded) + 16'd1 == count;
    assign tmo_en = state inside {CNT_LO, CNT_HI, DATA, CHECK};

    boot_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk(clk),
        .rst(rst),
        .clear(acc || !in_frame(state)),
        .enable(tmo_en),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:   next = start ? CNT_LO : boot_skip ? DONE : IDLE;
            CNT_LO: next = acc ? CNT_HI : CNT_LO;
            CNT_HI: next = !acc ? CNT_HI : cnt16 > 16'(IMEM_DEPTH) ? ERROR : cnt16 == 16'd0 ? CHECK : DATA;
            DATA:   next = acc && bidx == 2'd3 ? WRITE : DATA;
            WRITE:  next = last ? CHECK : DATA;
            CHECK:  next = !acc ? CHECK : in_data == csum ? DONE : ERROR;
            default: next = start ? CNT_LO : state;
        endcase
        // a byte landing on the expiry cycle keeps the frame alive
        if (expired && !acc) next = ERROR;
        err_n = start ? ERR_NONE
              : state == CNT_HI && acc && cnt16 > 16'(IMEM_DEPTH) ? ERR_OVF
              : state == CHECK && acc && in_data != csum ? ERR_CSUM
              : expired && !acc ? ERR_TMO
              : err;
    end

    always_comb begin
        in_ready = rst && state != WRITE;
        acc = in_valid && in_ready;
        start = acc && in_data == SYNC_BYTE && state inside {IDLE, DONE, ERROR};
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            core_rst <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
            err <= ERR_NONE;
            imem_we <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            words_loaded <= '0;
            csum <= '0;
            cnt_lo <= '0;
            count <= '0;
            bidx <= '0;
            buf_q <= '0;
        end else begin
            core_rst <= state != DONE;
            busy <= in_frame(next);
            done <= next == DONE;
            imem_we <= next == WRITE;
            err <= err_n;
            if (start) csum <= '0;
            else if (acc && state inside {CNT_LO, CNT_HI, DATA}) csum <= csum ^ in_data;
            if (acc && state == CNT_LO) cnt_lo <= in_data;
            if (acc && state == CNT_HI) begin
                count <= cnt16;
                bidx <= '0;
            end
            if (acc && state == DATA) begin
                bidx <= bidx + 1'b1;
                buf_q <= {in_data, buf_q[23:8]};
                if (bidx == 2'd3) imem_wdata <= {in_data, buf_q};
            end
            if (start) begin
                imem_waddr <= '0;
                words_loaded <= '0;
            end else if (state == WRITE) begin
                words_loaded <= words_loaded + 1'b1;
                if (!last) imem_waddr <= imem_waddr + 1'b1;
            end
        end
endmodule
